nand_flash_responder: RTL and testbench
=======================================

# nand_flash_responder

Synthesizable device-side responder for the 8-bit NAND flash bus driven by the NFC controller. Decodes CLE/ALE/WEn/REn strobe cycles into read, program, status and reset operations, and maps them onto a synchronous single-port backing memory (512 pages × 512 bytes). It stands in for flash_a/flash_b in FPGA prototypes and serves as the golden device model in gate-level regressions.

## Interface
- PAGE_W, 9, row (page) address width; 512 pages
- COL_W, 9, column width; 512 bytes per page
- T_PROG, 64, busy cycles after program confirm (10h)
- T_READ, 16, busy cycles after read address phase
- T_RST, 8, busy cycles after reset command (FFh)
- clk  in  1  clock; all strobes sampled on rising edge
- rst  in  1  asynchronous active-high reset
- F_IO  inout  8  flash data/command/address bus
- F_CLE  in  1  command latch enable
- F_ALE  in  1  address latch enable
- F_REN  in  1  read enable, active low
- F_WEN  in  1  write enable, active low
- F_RB  out  1  ready(1)/busy(0)
- mem_addr  out  18  backing address {row, col}
- mem_wdata  out  8  write data
- mem_we  out  1  write strobe, one cycle per byte
- mem_re  out  1  read strobe; mem_rdata valid next cycle
- mem_rdata  in  8  read data

## Operation
- Strobes registered once (wen_q, ren_q). Write event: wen_q=0 and F_WEN=1; F_IO captured that cycle. Read event: ren_q=1 and F_REN=0.
- Write event classification: CLE=1,ALE=0 command; CLE=0,ALE=1 address; both 0 data; both 1 ignored.
- Commands: 00h read, half=0; 01h read, half=1 (column bit 8); 80h program setup; 10h program confirm; 70h read status; FFh reset (accepted in any state, including busy). Any other command, or any command except 70h/FFh while busy, ignored.
- Address phase: 3 cycles: col[7:0], row[7:0], row[8] (bit 0; bits 7:1 ignored). col[8]=half. Extra address cycles ignored.
- States: IDLE, ADDR, READ_BUSY, READ_DATA, PROG_DATA, PROG_BUSY, STATUS, RST_BUSY.
- Read: 00h/01h → ADDR → after 3rd byte READ_BUSY (F_RB=0, T_READ cycles) → READ_DATA. Each read event: mem_re=1 at current address; byte driven on F_IO until F_REN rises; address increments on F_REN rising. col 511 → col 0, row+1; row 511 wraps to 0.
- Program: 80h → ADDR → PROG_DATA. Each data write: mem_we=1, mem_wdata=F_IO, col+1. Bytes beyond col 511 dropped (no wrap). 10h → PROG_BUSY (T_PROG) → IDLE.
- half resets to 0 after every read or program completes; 01h applies to one operation.
- Status: 70h → STATUS; any read event drives 8'hC0 when ready, 8'h80 when busy; underlying busy timer keeps counting; on expiry return to prior flow (READ_DATA/IDLE). Next command leaves STATUS.
- Reset: FFh aborts any operation, clears address, half=0, F_RB=0 for T_RST, then IDLE. Partial program bytes already written stay written.
- F_IO driven only when F_REN=0 (registered) in READ_DATA or STATUS; otherwise high-Z.

## Timing
- Reset values: F_RB=1, F_IO high-Z, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, state IDLE.
- F_RB falls the cycle after the write event that starts busy; high exactly T_x cycles later.
- Read latency: read event at cycle t → mem_re at t → F_IO valid from t+2 until one cycle after F_REN sampled high. Controller must hold F_REN low ≥3 cycles.
- Program: mem_we asserted cycle t+1 after data write event at t, single cycle.
- Busy counter width ≥ clog2(max T)+1; no back-pressure on memory port.
- rst mid-operation: immediate return to reset values; no mem strobes until next command.

## Test plan
- Reset: rst pulse mid-PROG_BUSY → F_RB=1, F_IO=Z, mem_we=0 within same cycle; subsequent 70h read returns 8'hC0.
- Program/read: 80h, addr 00,05,00, bytes 01..FF, 10h → F_RB low 64 cycles; 00h, addr 00,05,00 → after 16 busy cycles 255 reads return 01..FF, mem_addr starts 18'h00A00.
- Half pointer: 01h, addr 10,00,00 → first byte from mem_addr 18'h00110; following 00h read of same address starts at 18'h00010.
- Read wrap: read row 511 col 511 → next byte from mem_addr 0.
- Program overflow: 80h at col 510, 4 data bytes → exactly 2 mem_we pulses (cols 510, 511).
- Status and abort: 70h during PROG_BUSY → 8'h80; FFh during PROG_BUSY → F_RB low 8 cycles, then 70h → 8'hC0; undefined command 30h → no state change.

Source files
------------

// File: rtl/nand_flash_responder.sv
// nand_flash_responder: device side of the 8-bit NAND bus.
// Decodes CLE/ALE/WEn/REn strobe cycles into read, program, status and reset
// operations on a synchronous single-port backing memory addressed {row, col}.
// Column width is fixed at 9 (col[8] comes from the half pointer) and the
// row address arrives as two bytes (row[7:0], then row[PAGE_W-1:8]).
module nand_flash_responder #(
    parameter int PAGE_W = 9,
    parameter int COL_W  = 9,
    parameter int T_PROG = 64,
    parameter int T_READ = 16,
    parameter int T_RST  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    inout  wire  [7:0]                F_IO,
    input  logic                      F_CLE,
    input  logic                      F_ALE,
    input  logic                      F_REN,
    input  logic                      F_WEN,
    output logic                      F_RB,
    output logic [PAGE_W+COL_W-1:0]   mem_addr,
    output logic [7:0]                mem_wdata,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [7:0]                mem_rdata
);

    localparam int A_W   = PAGE_W + COL_W;
    localparam int T_MAX = (T_PROG > T_READ) ? ((T_PROG > T_RST) ? T_PROG : T_RST)
                                             : ((T_READ > T_RST) ? T_READ : T_RST);
    localparam int CNT_W = $clog2(T_MAX) + 1;

    localparam logic [7:0] CMD_READ0 = 8'h00;
    localparam logic [7:0] CMD_READ1 = 8'h01;
    localparam logic [7:0] CMD_PROG  = 8'h80;
    localparam logic [7:0] CMD_CONF  = 8'h10;
    localparam logic [7:0] CMD_STAT  = 8'h70;
    localparam logic [7:0] CMD_RST   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_READ_BUSY, S_READ_DATA,
        S_PROG_DATA, S_PROG_BUSY, S_STATUS, S_RST_BUSY
    } state_t;

    state_t state, nxt, ret_state;

    logic             wen_q, ren_q;
    logic             wr_ev, rd_ev, rd_rise;
    logic             cmd_ev, adr_ev, dat_ev, cmd_ok;
    logic [7:0]       io_in;
    logic             is_prog, half, col_ovf, rd_pend, re_q;
    logic [1:0]       addr_cnt;
    logic [PAGE_W-1:0] row;
    logic [COL_W-1:0]  col;
    logic [A_W-1:0]   wr_addr;
    logic [CNT_W-1:0] busy_cnt, cnt_load_val;
    logic             cnt_load;
    logic [7:0]       dout, out_byte;
    logic             busy, timer_done, io_oe;

    function automatic logic is_busy_st(state_t s);
        return (s == S_READ_BUSY) || (s == S_PROG_BUSY) || (s == S_RST_BUSY);
    endfunction

    // Where a busy phase lands once its timer runs out.
    function automatic state_t follow(state_t s);
        return (s == S_READ_BUSY) ? S_READ_DATA : S_IDLE;
    endfunction

    assign io_in = F_IO;

    // Strobe edge detection and cycle classification.
    always_comb begin
        wr_ev      = !wen_q && F_WEN;
        rd_ev      = ren_q && !F_REN;
        rd_rise    = !ren_q && F_REN;
        cmd_ev     = wr_ev && F_CLE && !F_ALE;
        adr_ev     = wr_ev && !F_CLE && F_ALE;
        dat_ev     = wr_ev && !F_CLE && !F_ALE;
        // STATUS keeps the busy timer of the flow it interrupted.
        busy       = is_busy_st(state) || ((state == S_STATUS) && is_busy_st(ret_state));
        timer_done = busy && (busy_cnt == CNT_W'(1));
        // Only status and reset get through while busy.
        cmd_ok     = cmd_ev && ((io_in == CMD_RST) || (io_in == CMD_STAT) || !busy);
    end

    // Next-state logic; an accepted command overrides timer expiry.
    always_comb begin
        nxt          = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        if (timer_done)
            nxt = follow((state == S_STATUS) ? ret_state : state);
        if (adr_ev && (state == S_ADDR) && (addr_cnt == 2'd2)) begin
            if (is_prog) begin
                nxt = S_PROG_DATA;
            end else begin
                nxt          = S_READ_BUSY;
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(T_READ);
            end
        end
        if (cmd_ok) begin
            case (io_in)
                CMD_RST: begin
                    nxt          = S_RST_BUSY;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(T_RST);
                end
                CMD_STAT: nxt = S_STATUS;
                CMD_READ0, CMD_READ1, CMD_PROG: nxt = S_ADDR;
                CMD_CONF: begin
                    if ((state == S_PROG_DATA) ||
                        ((state == S_STATUS) && (ret_state == S_PROG_DATA))) begin
                        nxt          = S_PROG_BUSY;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(T_PROG);
                    end
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    // Remember the flow STATUS interrupted; advance it if its timer expires meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_state <= S_IDLE;
        end else if ((nxt == S_STATUS) && (state != S_STATUS)) begin
            ret_state <= timer_done ? follow(state) : state;
        end else if ((state == S_STATUS) && timer_done) begin
            ret_state <= follow(ret_state);
        end
    end

    // Busy timer: loaded on entry to a busy phase, counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   busy_cnt <= '0;
        else if (cnt_load)         busy_cnt <= cnt_load_val;
        else if (busy_cnt != '0)   busy_cnt <= busy_cnt - CNT_W'(1);
    end

    // Strobe registers, address pointer, program path and read data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q     <= 1'b1;
            ren_q     <= 1'b1;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wr_addr   <= '0;
            re_q      <= 1'b0;
            dout      <= '0;
            row       <= '0;
            col       <= '0;
            half      <= 1'b0;
            is_prog   <= 1'b0;
            col_ovf   <= 1'b0;
            rd_pend   <= 1'b0;
            addr_cnt  <= '0;
        end else begin
            wen_q  <= F_WEN;
            ren_q  <= F_REN;
            mem_we <= 1'b0;
            re_q   <= mem_re;
            if (re_q) dout <= mem_rdata;

            // Sequential read pointer advances when REn returns high.
            if (state == S_READ_DATA) begin
                if (rd_ev) begin
                    rd_pend <= 1'b1;
                end else if (rd_rise && rd_pend) begin
                    rd_pend    <= 1'b0;
                    {row, col} <= {row, col} + A_W'(1);
                end
            end

            // Program data: one memory write per byte, nothing past the last column.
            if (dat_ev && (state == S_PROG_DATA) && !col_ovf) begin
                mem_we    <= 1'b1;
                mem_wdata <= io_in;
                wr_addr   <= {row, col};
                if (col == '1) col_ovf <= 1'b1;
                else           col     <= col + COL_W'(1);
            end

            // Three address bytes; extra ones fall through once ADDR is left.
            if (adr_ev && (state == S_ADDR)) begin
                case (addr_cnt)
                    2'd0: col <= {half, io_in};
                    2'd1: row[7:0] <= io_in;
                    2'd2: begin
                        row[PAGE_W-1:8] <= io_in[PAGE_W-9:0];
                        half            <= 1'b0;
                    end
                    default: ;
                endcase
                if (addr_cnt != 2'd3) addr_cnt <= addr_cnt + 2'd1;
            end

            // Command side effects; last so reset wins over a pointer update.
            if (cmd_ok) begin
                case (io_in)
                    CMD_RST: begin
                        row      <= '0;
                        col      <= '0;
                        half     <= 1'b0;
                        is_prog  <= 1'b0;
                        col_ovf  <= 1'b0;
                        rd_pend  <= 1'b0;
                        addr_cnt <= '0;
                    end
                    CMD_READ0: begin
                        half     <= 1'b0;
                        is_prog  <= 1'b0;
                        rd_pend  <= 1'b0;
                        addr_cnt <= '0;
                    end
                    CMD_READ1: begin
                        half     <= 1'b1;
                        is_prog  <= 1'b0;
                        rd_pend  <= 1'b0;
                        addr_cnt <= '0;
                    end
                    CMD_PROG: begin
                        is_prog  <= 1'b1;
                        col_ovf  <= 1'b0;
                        addr_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory port and bus outputs.
    always_comb begin
        mem_re   = (state == S_READ_DATA) && rd_ev;
        mem_addr = mem_we ? wr_addr : {row, col};
        out_byte = (state == S_STATUS) ? (busy ? 8'h80 : 8'hC0) : dout;
        io_oe    = !ren_q && ((state == S_READ_DATA) || (state == S_STATUS));
        F_RB     = !busy;
    end

    assign F_IO = io_oe ? out_byte : 8'hzz;

endmodule

// File: tb/tb_nand_flash_responder.sv
// Bench for nand_flash_responder: drives NAND bus cycles, models the backing
// memory, and scoreboards memory strobes and read data against expectations.
module tb_nand_flash_responder;

    logic        clk = 1'b0;
    logic        rst;
    wire  [7:0]  F_IO;
    logic [7:0]  io_drv;
    logic        io_en;
    logic        F_CLE, F_ALE, F_REN, F_WEN, F_RB;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    logic        pl_we;
    logic [17:0] pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  mem [0:262143];

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;

    logic [17:0] exp_ra_q[$];
    logic [25:0] exp_wa_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [17:0] mon_ra;
    logic [25:0] mon_wa;

    assign F_IO = io_en ? io_drv : 8'hzz;

    always #5 clk = ~clk;

    nand_flash_responder dut (
        .clk(clk), .rst(rst), .F_IO(F_IO), .F_CLE(F_CLE), .F_ALE(F_ALE),
        .F_REN(F_REN), .F_WEN(F_WEN), .F_RB(F_RB), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    // Synchronous backing memory with a bench-side preload port.
    always @(posedge clk) begin
        if (pl_we)  mem[pl_addr] <= pl_data;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Memory strobe scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            if (mem_re) begin
                tests++;
                if (exp_ra_q.size() == 0) begin
                    fails++;
                    $display("FAIL mem_re_addr: unexpected read strobe at %h", mem_addr);
                end else begin
                    mon_ra = exp_ra_q.pop_front();
                    if (mem_addr !== mon_ra) begin
                        fails++;
                        $display("FAIL mem_re_addr: got %h expected %h", mem_addr, mon_ra);
                    end
                end
            end
            if (mem_we) begin
                we_cnt++;
                tests++;
                if (exp_wa_q.size() == 0) begin
                    fails++;
                    $display("FAIL mem_we: unexpected write %h <= %h", mem_addr, mem_wdata);
                end else begin
                    mon_wa = exp_wa_q.pop_front();
                    if ({mem_addr, mem_wdata} !== mon_wa) begin
                        fails++;
                        $display("FAIL mem_we: got %h/%h expected %h/%h",
                                 mem_addr, mem_wdata, mon_wa[25:8], mon_wa[7:0]);
                    end
                end
            end
        end
    end

    task automatic preload(input logic [17:0] a, input logic [7:0] d);
        @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk); pl_we = 1'b0;
    endtask

    task automatic wr_cyc(input logic cle, input logic ale, input logic [7:0] d);
        @(negedge clk); F_CLE = cle; F_ALE = ale; io_drv = d; io_en = 1'b1; F_WEN = 1'b0;
        @(negedge clk); F_WEN = 1'b1;
        @(negedge clk); F_CLE = 1'b0; F_ALE = 1'b0; io_en = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] c);
        wr_cyc(1'b1, 1'b0, c);
    endtask

    task automatic addr3(input logic [7:0] c, input logic [7:0] r0, input logic [7:0] r1);
        wr_cyc(1'b0, 1'b1, c);
        wr_cyc(1'b0, 1'b1, r0);
        wr_cyc(1'b0, 1'b1, r1);
    endtask

    task automatic wdata(input logic [17:0] a, input logic [7:0] d, input bit expect_we);
        if (expect_we) exp_wa_q.push_back({a, d});
        wr_cyc(1'b0, 1'b0, d);
    endtask

    task automatic rd(output logic [7:0] d);
        @(negedge clk); F_REN = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        d = F_IO; F_REN = 1'b1;
        @(negedge clk);
    endtask

    task automatic read_expect(input string name, input logic [17:0] a, input logic [7:0] d);
        logic [7:0] got, e;
        exp_ra_q.push_back(a);
        exp_rd_q.push_back(d);
        rd(got);
        e = exp_rd_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (addr %h)", name, got, e, a);
        end
    endtask

    task automatic status_expect(input string name, input logic [7:0] s);
        logic [7:0] got, e;
        exp_rd_q.push_back(s);
        rd(got);
        e = exp_rd_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, e);
        end
    endtask

    task automatic wait_rb(input string name, input int exp_cycles);
        int n = 0;
        while (F_RB === 1'b0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (n != exp_cycles) begin
            fails++;
            $display("FAIL %s: busy for %0d cycles, expected %0d", name, n, exp_cycles);
        end
    endtask

    task automatic test_reset_values();
        tests++;
        if ({F_RB, mem_we, mem_re} !== 3'b100) begin
            fails++;
            $display("FAIL reset_strobes: got rb/we/re %b expected 100", {F_RB, mem_we, mem_re});
        end
        tests++;
        if ({mem_addr, mem_wdata} !== 26'd0) begin
            fails++;
            $display("FAIL reset_mem_port: got %h/%h expected 0/0", mem_addr, mem_wdata);
        end
        io_drv = 8'hA5; io_en = 1'b1; #1;
        tests++;
        if (F_IO !== 8'hA5) begin
            fails++;
            $display("FAIL reset_io_release: got %h expected a5", F_IO);
        end
        io_en = 1'b0;
    endtask

    task automatic test_prog_read();
        cmd(8'h80); addr3(8'h00, 8'h05, 8'h00);
        for (int i = 0; i < 255; i++) wdata(18'h00A00 + 18'(i), 8'(i + 1), 1'b1);
        cmd(8'h10);
        wait_rb("prog_busy", 64);
        cmd(8'h00); addr3(8'h00, 8'h05, 8'h00);
        wait_rb("read_busy", 16);
        for (int i = 0; i < 255; i++) read_expect("page_read", 18'h00A00 + 18'(i), 8'(i + 1));
    endtask

    task automatic test_half();
        preload(18'h00110, 8'h11);
        preload(18'h00111, 8'h12);
        preload(18'h00010, 8'h22);
        cmd(8'h01); addr3(8'h10, 8'h00, 8'h00);
        wait_rb("half_busy", 16);
        read_expect("half_first", 18'h00110, 8'h11);
        cmd(8'h30);
        read_expect("undef_cmd_in_read", 18'h00111, 8'h12);
        cmd(8'h00); addr3(8'h10, 8'h00, 8'h00);
        wait_rb("lower_busy", 16);
        read_expect("half_cleared", 18'h00010, 8'h22);
    endtask

    task automatic test_wrap();
        preload(18'h3FFFF, 8'h5A);
        preload(18'h00000, 8'hA5);
        cmd(8'h01); addr3(8'hFF, 8'hFF, 8'h01);
        wait_rb("wrap_busy", 16);
        read_expect("wrap_last", 18'h3FFFF, 8'h5A);
        read_expect("wrap_zero", 18'h00000, 8'hA5);
    endtask

    task automatic test_overflow();
        int base;
        preload(18'h00800, 8'h77);
        base = we_cnt;
        cmd(8'h01); cmd(8'h80); addr3(8'hFE, 8'h03, 8'h00);
        wdata(18'h007FE, 8'h31, 1'b1);
        wdata(18'h007FF, 8'h32, 1'b1);
        wdata(18'h00000, 8'h33, 1'b0);
        wdata(18'h00000, 8'h34, 1'b0);
        @(negedge clk); @(negedge clk);
        tests++;
        if (we_cnt - base != 2) begin
            fails++;
            $display("FAIL overflow_we_count: got %0d expected 2", we_cnt - base);
        end
        cmd(8'h10);
        wait_rb("overflow_prog_busy", 64);
        cmd(8'h01); addr3(8'hFE, 8'h03, 8'h00);
        wait_rb("overflow_read_busy", 16);
        read_expect("overflow_rd510", 18'h007FE, 8'h31);
        read_expect("overflow_rd511", 18'h007FF, 8'h32);
        read_expect("overflow_next_row", 18'h00800, 8'h77);
    endtask

    task automatic test_status_abort();
        cmd(8'h80); addr3(8'h00, 8'h07, 8'h00);
        wdata(18'h00E00, 8'h99, 1'b1);
        cmd(8'h10);
        tests++;
        if (F_RB !== 1'b0) begin
            fails++;
            $display("FAIL prog_rb_low: got %b expected 0", F_RB);
        end
        cmd(8'h70);
        status_expect("status_busy", 8'h80);
        cmd(8'hFF);
        wait_rb("rst_busy", 8);
        cmd(8'h70);
        status_expect("status_ready", 8'hC0);
        cmd(8'h30);
        status_expect("undef_cmd_in_status", 8'hC0);
        tests++;
        if (F_RB !== 1'b1) begin
            fails++;
            $display("FAIL undef_cmd_rb: got %b expected 1", F_RB);
        end
    endtask

    task automatic test_reset_mid_prog();
        cmd(8'h80); addr3(8'h00, 8'h08, 8'h00);
        wdata(18'h01000, 8'h44, 1'b1);
        cmd(8'h10);
        repeat (5) @(negedge clk);
        rst = 1'b1; #1;
        tests++;
        if ({F_RB, mem_we, mem_re} !== 3'b100) begin
            fails++;
            $display("FAIL rst_mid_prog: got rb/we/re %b expected 100", {F_RB, mem_we, mem_re});
        end
        io_drv = 8'h3C; io_en = 1'b1; #1;
        tests++;
        if (F_IO !== 8'h3C) begin
            fails++;
            $display("FAIL rst_mid_prog_io: got %h expected 3c", F_IO);
        end
        io_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        cmd(8'h70);
        status_expect("status_after_rst", 8'hC0);
    endtask

    initial begin
        rst = 1'b1; F_CLE = 1'b0; F_ALE = 1'b0; F_WEN = 1'b1; F_REN = 1'b1;
        io_en = 1'b0; io_drv = 8'h00; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        test_reset_values();
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        test_prog_read();
        test_half();
        test_wrap();
        test_overflow();
        test_status_abort();
        test_reset_mid_prog();
        repeat (4) @(negedge clk);
        tests++;
        if (exp_ra_q.size() != 0 || exp_wa_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d reads and %0d writes never seen",
                     exp_ra_q.size(), exp_wa_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
